// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-controller state encoding and PC defaults,
// used by the PC redirect controller, imem and branch-decision blocks.
package cpu_pkg;

    localparam int PC_W_DEF     = 9;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PEND  = 2'd2
    } redir_state_t;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Fetch-side PC owner. Applies EX-stage branch redirects, raises a
// multi-cycle flush for the younger pipeline registers, and parks a redirect
// that arrives while the core is frozen until the freeze is released.
//
// state | meaning
// RUN   | normal fetch: increment, stall hold, or take a redirect
// FLUSH | redirect taken; flush high while flush_cnt counts down to 0
// PEND  | redirect seen during freeze; pend_target applied on release
module pc_redirect_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int RESET_PC     = RESET_PC_DEF,
    parameter int PC_INC       = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             stall,
    input  logic             freeze,
    output logic [PC_W-1:0]  pc,
    output logic             flush,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_count
);

    // 3 bits covers the legal FLUSH_CYCLES range of 1..7
    localparam int FC_W = 3;

    redir_state_t    state;
    logic [FC_W-1:0] flush_cnt;
    logic [PC_W-1:0] pend_target;

    logic            take_redirect;
    logic [PC_W-1:0] redirect_target;

    // Redirect decision: a live branch in RUN, or release of a parked one in PEND
    always_comb begin
        take_redirect   = 1'b0;
        redirect_target = branch_target;
        case (state)
            ST_RUN: take_redirect = !freeze && branch;
            ST_PEND: begin
                take_redirect   = !freeze;
                redirect_target = pend_target;
            end
            default: take_redirect = 1'b0;
        endcase
    end

    assign redirect_pending = (state == ST_PEND);

    // Controller FSM with registered pc/flush/count
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            pc             <= PC_W'(RESET_PC);
            flush          <= 1'b0;
            flush_cnt      <= '0;
            pend_target    <= '0;
            redirect_count <= '0;
        end else if (take_redirect) begin
            pc             <= redirect_target;
            flush          <= 1'b1;
            flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
            redirect_count <= redirect_count + CNT_W'(1);
            state          <= ST_FLUSH;
        end else begin
            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        if (branch) begin
                            pend_target <= branch_target;
                            state       <= ST_PEND;
                        end
                    end else if (!stall) begin
                        pc <= pc + PC_W'(PC_INC);
                    end
                end
                ST_FLUSH: begin
                    // branch/stall here come from squashed slots and are ignored
                    if (!freeze) begin
                        pc <= pc + PC_W'(PC_INC);
                        if (flush_cnt == '0) begin
                            flush <= 1'b0;
                            state <= ST_RUN;
                        end else begin
                            flush_cnt <= flush_cnt - FC_W'(1);
                        end
                    end
                end
                ST_PEND: begin
                    // frozen: hold; release is handled by take_redirect
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl (default parameters).
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        branch;
    logic [8:0]  branch_target;
    logic        stall;
    logic        freeze;
    logic [8:0]  pc;
    logic        flush;
    logic        redirect_pending;
    logic [15:0] redirect_count;

    int n_checks = 0;
    int n_errors = 0;

    pc_redirect_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .branch           (branch),
        .branch_target    (branch_target),
        .stall            (stall),
        .freeze           (freeze),
        .pc               (pc),
        .flush            (flush),
        .redirect_pending (redirect_pending),
        .redirect_count   (redirect_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then compare all outputs 1 time unit after the edge
    task automatic tick(input string tag, input int e_pc, input int e_flush,
                        input int e_pend, input int e_cnt);
        @(posedge clk);
        #1;
        check({tag, ".pc"},    int'(pc),               e_pc);
        check({tag, ".flush"}, int'(flush),            e_flush);
        check({tag, ".pend"},  int'(redirect_pending), e_pend);
        check({tag, ".cnt"},   int'(redirect_count),   e_cnt);
    endtask

    initial begin
        reset = 1'b1; branch = 1'b0; branch_target = '0; stall = 1'b0; freeze = 1'b0;
        tick("rst0", 0, 0, 0, 0);
        tick("rst1", 0, 0, 0, 0);
        reset = 1'b0;

        // 1: free running
        tick("run1", 1, 0, 0, 0);
        tick("run2", 2, 0, 0, 0);
        tick("run3", 3, 0, 0, 0);
        tick("run4", 4, 0, 0, 0);
        tick("run5", 5, 0, 0, 0);

        // 2: redirect to 0x40; branch held through flush is ignored
        branch = 1'b1; branch_target = 9'h040;
        tick("br_a", 'h40, 1, 0, 1);
        branch_target = 9'h077;
        tick("br_b", 'h41, 1, 0, 1);
        tick("br_c", 'h42, 0, 0, 1);

        // 3: branch + stall (back-to-back with previous flush), then stall alone
        branch = 1'b1; stall = 1'b1; branch_target = 9'h010;
        tick("bs_a", 'h10, 1, 0, 2);
        branch = 1'b0;
        tick("bs_b", 'h11, 1, 0, 2);
        tick("bs_c", 'h12, 0, 0, 2);
        tick("st_a", 'h12, 0, 0, 2);
        tick("st_b", 'h12, 0, 0, 2);
        stall = 1'b0;
        tick("st_c", 'h13, 0, 0, 2);

        // 4: branch while frozen is parked, applied on release, pc wraps
        freeze = 1'b1; branch = 1'b1; branch_target = 9'h1FF;
        check("fz_pre.pend", int'(redirect_pending), 0);
        tick("fz_a", 'h13, 0, 1, 2);
        branch_target = 9'h055;
        tick("fz_b", 'h13, 0, 1, 2);
        tick("fz_c", 'h13, 0, 1, 2);
        freeze = 1'b0; branch = 1'b0;
        tick("rel_a", 'h1FF, 1, 0, 3);
        tick("rel_b", 'h000, 1, 0, 3);
        tick("rel_c", 'h001, 0, 0, 3);

        // 5: freeze mid-flush holds pc and flush
        branch = 1'b1; branch_target = 9'h080;
        tick("ff_a", 'h80, 1, 0, 4);
        branch = 1'b0; freeze = 1'b1;
        tick("ff_b", 'h80, 1, 0, 4);
        tick("ff_c", 'h80, 1, 0, 4);
        freeze = 1'b0;
        tick("ff_d", 'h81, 1, 0, 4);
        tick("ff_e", 'h82, 0, 0, 4);

        // 6: reset mid-flush and in PEND
        branch = 1'b1; branch_target = 9'h020;
        tick("rf_a", 'h20, 1, 0, 5);
        reset = 1'b1; branch = 1'b0;
        tick("rf_b", 0, 0, 0, 0);
        reset = 1'b0;
        tick("rf_c", 1, 0, 0, 0);
        freeze = 1'b1; branch = 1'b1; branch_target = 9'h033;
        tick("rp_a", 1, 0, 1, 0);
        reset = 1'b1;
        tick("rp_b", 0, 0, 0, 0);
        reset = 1'b0; freeze = 1'b0; branch = 1'b0;
        tick("rp_c", 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
